// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised synchronous FIFO with first-word-fall-through read data.
//   DEPTH = 2**ADDR_WIDTH entries of DATA_WIDTH bits. Occupancy is held in a
//   count register; every status flag is a decode of that register, so no
//   output has a combinational path from wr_en or rd_en.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high; returns block to power-on state
//   flush        synchronous clear of contents (error flags kept)
//   wr_en        push request
//   wr_data      push data
//   rd_en        pop request (consumer samples rd_data in the same cycle)
//   rd_data      head entry, 0 when empty
//   count        occupancy 0..DEPTH
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= DEPTH - AF_MARGIN
//   almost_empty count <= AE_MARGIN
//   err_clr      clears overflow/underflow (a coincident new error wins)
//   overflow     sticky: a push was dropped
//   underflow    sticky: a pop was ignored
module fifo_sync_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   AF_TH    = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_WIDTH:0]   AE_TH    = (ADDR_WIDTH+1)'(AE_MARGIN);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [ADDR_WIDTH-1:0]            wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]              count_q;
   logic                             ovf_q, unf_q;

   logic push_ok, pop_ok;
   logic ovf_evt, unf_evt;

   // Status decodes of the registered count only.
   assign full         = (count_q == CNT_FULL);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_TH);
   assign almost_empty = (count_q <= AE_TH);
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // Head entry; gated to 0 so stale memory never leaks out while empty.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // When full, a push is only accepted alongside a pop, which is
   // guaranteed to succeed since full implies non-empty.
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = wr_en & (~full | rd_en);

   // Flush discards the cycle's requests, so it also masks their errors.
   assign ovf_evt = ~flush & wr_en & full & ~rd_en;
   assign unf_evt = ~flush & rd_en & empty;

   // Storage is not reset; contents are unreachable until written.
   always_ff @(posedge clk) begin
      if (!reset && !flush && push_ok)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error bits: a new event in the same cycle overrides err_clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q & ~err_clr) | ovf_evt;
         unf_q <= (unf_q & ~err_clr) | unf_evt;
      end
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed testbench for fifo_sync_param (DATA_WIDTH 32, DEPTH 4,
// AF_MARGIN 1, AE_MARGIN 1). Inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_fifo_sync_param;

   logic        clk = 1'b0;
   logic        reset, flush, wr_en, rd_en, err_clr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [2:0]  count;
   logic        full, empty, almost_full, almost_empty, overflow, underflow;

   int checks = 0;
   int errors = 0;

   // {full, empty, almost_full, almost_empty} expected for count 0..4
   logic [3:0] flg_tab [5] = '{4'b0101, 4'b0001, 4'b0000, 4'b0010, 4'b1010};

   fifo_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
      .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         wr_en = 1; wr_data = base + 32'(i);
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      checks++;
      if ({count, full, empty, almost_full, almost_empty} !== {3'd0, 4'b0101}) begin
         errors++; $display("FAIL reset_status: got %b exp %b", {count, full, empty, almost_full, almost_empty}, {3'd0, 4'b0101});
      end
      checks++;
      if ({rd_data, overflow, underflow} !== {32'h0, 2'b00}) begin
         errors++; $display("FAIL reset_data_err: got %h/%b%b exp 0/00", rd_data, overflow, underflow);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1; wr_data = 32'hA0 + 32'(i);
         tick();
         checks++;
         if ({count, full, empty, almost_full, almost_empty} !== {3'(i + 1), flg_tab[i + 1]}) begin
            errors++; $display("FAIL fill_status[%0d]: got %b exp %b", i, {count, full, empty, almost_full, almost_empty}, {3'(i + 1), flg_tab[i + 1]});
         end
         checks++;
         if (rd_data !== 32'hA0) begin
            errors++; $display("FAIL fill_head[%0d]: got %h exp a0", i, rd_data);
         end
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         rd_en = 1;
         checks++;
         if (rd_data !== 32'hA0 + 32'(i)) begin
            errors++; $display("FAIL drain_data[%0d]: got %h exp %h", i, rd_data, 32'hA0 + 32'(i));
         end
         tick();
         checks++;
         if ({count, full, empty, almost_full, almost_empty} !== {3'(3 - i), flg_tab[3 - i]}) begin
            errors++; $display("FAIL drain_status[%0d]: got %b exp %b", i, {count, full, empty, almost_full, almost_empty}, {3'(3 - i), flg_tab[3 - i]});
         end
      end
      idle();
      checks++;
      if (rd_data !== 32'h0) begin
         errors++; $display("FAIL drain_empty_data: got %h exp 0", rd_data);
      end
   endtask

   task automatic test_overflow();
      push_n(4, 32'hA0);
      wr_en = 1; wr_data = 32'hFF;
      tick();
      idle();
      checks++;
      if ({overflow, underflow, count, full} !== {2'b10, 3'd4, 1'b1}) begin
         errors++; $display("FAIL ovf_set: got ovf=%b unf=%b cnt=%0d full=%b exp 1 0 4 1", overflow, underflow, count, full);
      end
      for (int i = 0; i < 4; i++) begin
         rd_en = 1;
         checks++;
         if (rd_data !== 32'hA0 + 32'(i)) begin
            errors++; $display("FAIL ovf_drain[%0d]: got %h exp %h", i, rd_data, 32'hA0 + 32'(i));
         end
         tick();
      end
      idle();
      checks++;
      if ({empty, rd_data} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL ovf_no_ff: empty=%b data=%h exp 1 0", empty, rd_data);
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow);
      end
      err_clr = 1;
      tick();
      idle();
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clr: got %b exp 0", overflow);
      end
   endtask

   task automatic test_back_to_back();
      push_n(4, 32'h100);
      for (int i = 0; i < 12; i++) begin
         wr_en = 1; rd_en = 1; wr_data = 32'h104 + 32'(i);
         checks++;
         if (rd_data !== 32'h100 + 32'(i)) begin
            errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, rd_data, 32'h100 + 32'(i));
         end
         tick();
         checks++;
         if ({count, full} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL b2b_full[%0d]: cnt=%0d full=%b exp 4 1", i, count, full);
         end
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         rd_en = 1;
         checks++;
         if (rd_data !== 32'h10C + 32'(i)) begin
            errors++; $display("FAIL b2b_tail[%0d]: got %h exp %h", i, rd_data, 32'h10C + 32'(i));
         end
         tick();
      end
      idle();
      checks++;
      if ({empty, overflow, underflow} !== 3'b100) begin
         errors++; $display("FAIL b2b_end: empty/ovf/unf=%b exp 100", {empty, overflow, underflow});
      end
   endtask

   task automatic test_underflow();
      rd_en = 1;
      tick();
      idle();
      checks++;
      if ({underflow, count, empty} !== {1'b1, 3'd0, 1'b1}) begin
         errors++; $display("FAIL unf_set: unf=%b cnt=%0d empty=%b exp 1 0 1", underflow, count, empty);
      end
      // clear and a new underflow in the same cycle: set wins
      rd_en = 1; err_clr = 1;
      tick();
      idle();
      checks++;
      if (underflow !== 1'b1) begin
         errors++; $display("FAIL unf_set_wins: got %b exp 1", underflow);
      end
      wr_en = 1; rd_en = 1; wr_data = 32'h55;
      tick();
      idle();
      checks++;
      if ({count, rd_data, underflow} !== {3'd1, 32'h55, 1'b1}) begin
         errors++; $display("FAIL empty_wr_rd: cnt=%0d data=%h unf=%b exp 1 55 1", count, rd_data, underflow);
      end
      rd_en = 1;
      tick();
      idle();
   endtask

   task automatic test_flush_reset();
      push_n(3, 32'hC0);
      flush = 1; wr_en = 1; wr_data = 32'hEE;
      tick();
      idle();
      checks++;
      if ({count, empty, rd_data} !== {3'd0, 1'b1, 32'h0}) begin
         errors++; $display("FAIL flush_state: cnt=%0d empty=%b data=%h exp 0 1 0", count, empty, rd_data);
      end
      checks++;
      if ({overflow, underflow} !== 2'b01) begin
         errors++; $display("FAIL flush_err_kept: got %b exp 01", {overflow, underflow});
      end
      push_n(1, 32'h77);
      checks++;
      if ({count, rd_data} !== {3'd1, 32'h77}) begin
         errors++; $display("FAIL flush_no_ee: cnt=%0d data=%h exp 1 77", count, rd_data);
      end
      push_n(2, 32'hD0);
      reset = 1; wr_en = 1; wr_data = 32'hEE;
      tick();
      idle();
      checks++;
      if ({count, full, empty, almost_full, almost_empty} !== {3'd0, 4'b0101}) begin
         errors++; $display("FAIL rst_mid_status: got %b exp %b", {count, full, empty, almost_full, almost_empty}, {3'd0, 4'b0101});
      end
      checks++;
      if ({rd_data, overflow, underflow} !== {32'h0, 2'b00}) begin
         errors++; $display("FAIL rst_mid_data_err: data=%h ovf=%b unf=%b exp 0 0 0", rd_data, overflow, underflow);
      end
      push_n(1, 32'h88);
      checks++;
      if ({count, rd_data} !== {3'd1, 32'h88}) begin
         errors++; $display("FAIL rst_mid_ptr: cnt=%0d data=%h exp 1 88", count, rd_data);
      end
   endtask

   initial begin
      idle();
      reset = 1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_back_to_back();
      test_underflow();
      test_flush_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
